// File: rtl/tdm_demux4_if.sv
// -----------------------------------------------------------------------------
// tdm_demux4_if
// Bundles the serial TDM input stream and the parallel valid/ready frame output
// of tdm_demux4.
//   in_bit      serial data bit
//   in_valid    in_bit is valid this cycle (no backpressure on the input)
//   frame_sync  first bit of a frame (lane 0 MSB), qualified by in_valid
//   out_data    assembled frame {lane3, lane2, lane1, lane0}
//   out_valid   out_data holds an undelivered frame
//   out_ready   downstream accepts out_data when out_valid && out_ready
// Modports: slave = demultiplexer view, master = link front end / consumer view.
// -----------------------------------------------------------------------------
interface tdm_demux4_if #(
    parameter int unsigned WORD_W = 8
);
    logic                  in_bit;
    logic                  in_valid;
    logic                  frame_sync;
    logic [4*WORD_W-1:0]   out_data;
    logic                  out_valid;
    logic                  out_ready;

    modport slave (
        input  in_bit,
        input  in_valid,
        input  frame_sync,
        input  out_ready,
        output out_data,
        output out_valid
    );

    modport master (
        output in_bit,
        output in_valid,
        output frame_sync,
        output out_ready,
        input  out_data,
        input  out_valid
    );
endinterface

// File: rtl/tdm_demux4.sv
// -----------------------------------------------------------------------------
// tdm_demux4
// Four-lane bit-serial TDM demultiplexer. Successive valid bits belong to lanes
// 0,1,2,3,0,...; each lane word is shifted in MSB first. A completed frame of
// 4*WORD_W bits is presented as one parallel valid/ready word.
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   bus       tdm_demux4_if.slave: serial input stream + frame output handshake
//   locked    high while in RUN
//   sync_err  one-cycle pulse after a misplaced frame_sync
//   overflow  sticky; a completed frame was dropped (cleared only by rst)
// WORD_W must be at least 2.
// -----------------------------------------------------------------------------
module tdm_demux4 #(
    parameter int unsigned WORD_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    tdm_demux4_if.slave       bus,
    output logic              locked,
    output logic              sync_err,
    output logic              overflow
);

    localparam int unsigned        BIT_W    = $clog2(WORD_W);
    localparam logic [BIT_W-1:0]   LAST_BIT = BIT_W'(WORD_W - 1);
    localparam logic [1:0]         LAST_SLOT = 2'd3;

    typedef enum logic {
        HUNT,
        RUN
    } state_t;

    state_t                state_q,     state_d;
    logic [1:0]            slot_q,      slot_d;
    logic [BIT_W-1:0]      bit_q,       bit_d;
    logic [WORD_W-1:0]     lane_q [4];
    logic [WORD_W-1:0]     lane_d [4];
    logic [4*WORD_W-1:0]   out_data_q,  out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  sync_err_q,  sync_err_d;
    logic                  overflow_q,  overflow_d;

    logic                  complete;
    logic                  handshake;
    logic                  at_frame_start;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HUNT;
            slot_q      <= '0;
            bit_q       <= '0;
            lane_q      <= '{default: '0};
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            bit_q       <= bit_d;
            lane_q      <= lane_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            sync_err_q  <= sync_err_d;
            overflow_q  <= overflow_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        bit_d       = bit_q;
        lane_d      = lane_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        sync_err_d  = 1'b0;
        overflow_d  = overflow_q;
        complete    = 1'b0;

        handshake      = out_valid_q && bus.out_ready;
        at_frame_start = (slot_q == 2'd0) && (bit_q == '0);

        if (handshake) begin
            out_valid_d = 1'b0;
        end

        // Idle cycles (in_valid=0) leave counters, lanes and state untouched.
        if (bus.in_valid) begin
            unique case (state_q)
                HUNT: begin
                    if (bus.frame_sync) begin
                        state_d   = RUN;
                        lane_d    = '{default: '0};
                        lane_d[0] = {{(WORD_W-1){1'b0}}, bus.in_bit};
                        slot_d    = 2'd1;
                        bit_d     = '0;
                    end
                end

                RUN: begin
                    if (bus.frame_sync && !at_frame_start) begin
                        // Misplaced sync: drop the partial frame and restart
                        // with this bit as lane 0 MSB. This takes precedence
                        // over completion on the final slot.
                        sync_err_d = 1'b1;
                        lane_d     = '{default: '0};
                        lane_d[0]  = {{(WORD_W-1){1'b0}}, bus.in_bit};
                        slot_d     = 2'd1;
                        bit_d      = '0;
                    end else begin
                        lane_d[slot_q] = {lane_q[slot_q][WORD_W-2:0], bus.in_bit};
                        if (slot_q == LAST_SLOT) begin
                            slot_d = 2'd0;
                            if (bit_q == LAST_BIT) begin
                                bit_d    = '0;
                                complete = 1'b1;
                            end else begin
                                bit_d = bit_q + BIT_W'(1);
                            end
                        end else begin
                            slot_d = slot_q + 2'd1;
                        end
                    end
                end

                default: begin
                    state_d = HUNT;
                end
            endcase
        end

        // A completed frame loads the output register when it is empty or
        // being drained this same cycle; otherwise it is lost.
        if (complete) begin
            if (!out_valid_q || bus.out_ready) begin
                out_data_d  = {lane_d[3], lane_d[2], lane_d[1], lane_d[0]};
                out_valid_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs (all driven straight from registers)
    // -------------------------------------------------------------------------
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign locked        = (state_q == RUN);
    assign sync_err      = sync_err_q;
    assign overflow      = overflow_q;

endmodule

// File: doc/tdm_demux4.md
# tdm_demux4

Four-lane time-division demultiplexer: the receive-side counterpart of the team's 4:1 lane-select mux. It accepts a single bit-serial TDM stream in which successive bits belong to lanes 0,1,2,3,0,… and reassembles one WORD_W-bit word per lane. A completed frame is presented as a parallel valid/ready word to downstream logic. The block sits between the serial link front end and the per-lane consumers, and reports lock, framing errors and overflow.

## Interface
- WORD_W, default 8: bits per lane word; must be ≥ 2.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_bit  input  1  serial data bit.
- in_valid  input  1  in_bit is valid this cycle. No input backpressure exists.
- frame_sync  input  1  qualified by in_valid; marks the first bit of a frame (lane 0, word MSB).
- out_data  output  4*WORD_W  assembled frame {lane3, lane2, lane1, lane0}.
- out_valid  output  1  out_data holds an undelivered frame.
- out_ready  input  1  downstream accepts out_data when out_valid && out_ready.
- locked  output  1  high while in RUN state.
- sync_err  output  1  one-cycle pulse on a misplaced frame_sync.
- overflow  output  1  sticky; a completed frame was dropped.

## Operation
- A frame is 4*WORD_W valid bits, lane-interleaved. The slot counter (2 bits) selects the lane and the bit counter (log2 WORD_W) gives the bit index. Each lane word is shifted in MSB first.
- Cycles with in_valid=0 are ignored entirely; no counter or state changes.
- State HUNT (reset state): valid bits without frame_sync are discarded. A valid bit with frame_sync moves the block to RUN, and that bit is captured as lane 0 bit WORD_W-1, with the slot counter advancing to 1.
- State RUN: each valid bit is written into lane[slot], and the slot counter increments modulo 4. The bit counter increments when the slot wraps 3→0.
- frame_sync is optional after lock, but permitted only on the first bit of a frame:
  - If it arrives at slot 0 with bit count 0, it is accepted silently.
  - If it arrives anywhere else, sync_err pulses the next cycle. The partial frame is discarded, and the current bit restarts a frame as lane 0 MSB. The block remains in RUN.
- Frame completion is the valid bit at slot 3 with the final bit index. On completion the counters return to zero and the four lane words are transferred to the output register as follows:
  - If out_valid=0, or out_valid && out_ready in the same cycle: load out_data and set out_valid.
  - Otherwise: the new frame is dropped, out_data is unchanged, and overflow is set. overflow clears only on rst.
- A handshake with no completion that cycle clears out_valid.
- Reset values: out_data=0, out_valid=0, locked=0, sync_err=0, overflow=0, state=HUNT, all counters and lane shift registers 0.
- rst mid-frame discards the partial frame and any pending output; the block must resynchronise from HUNT.

## Timing
- Single clock domain; all outputs are registered.
- out_valid rises on the edge that samples the completing bit, so it is visible the cycle after that bit.
- Minimum frame period is 4*WORD_W cycles at in_valid=1 continuously. If out_ready is held high, back-to-back frames never overflow.
- out_data is stable while out_valid=1 and out_ready=0.
- locked rises the cycle after the syncing bit is sampled and falls only on rst.
- sync_err is high for exactly one cycle per misplaced sync.
- A misplaced frame_sync on the completing slot counts as a resync, not a completion.

## Test plan
- WORD_W=8, sync then continuous stream of lanes 0xA5,0x3C,0xFF,0x01 -> out_valid one cycle after bit 32, out_data=0x01FF3CA5, locked=1, sync_err=0.
- Same frame with in_valid low on random cycles (gaps of 1–5) -> identical out_data=0x01FF3CA5; the gaps cause no bit loss or duplication.
- 10 valid bits without frame_sync, then a synced frame -> first 10 bits ignored, locked stays 0 until the sync bit, out_data equals the synced frame only.
- frame_sync reasserted at bit 13 of a frame -> sync_err pulses once, partial frame dropped; the next 32 bits from bit 13 produce the expected word.
- out_ready held 0 across two completed frames -> first frame held unchanged, second dropped, overflow=1 and stays 1; out_ready=1 then delivers the first frame.
- rst asserted at bit 20 -> all outputs 0 next cycle, state HUNT; a following synced frame decodes correctly.
